// File: rtl/dpsram_pingpong_ctrl_pkg.sv
// Shared types and defaults for the ping-pong DPSRAM controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dpsram_pingpong_ctrl_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 64;
    localparam int BANK_WORDS = 1 << (DEF_ADDR_W - 1);

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_st_e;

    // A bank can take write data until it has been closed.
    function automatic logic bank_writable(input bank_st_e st);
        return (st == BANK_EMPTY) || (st == BANK_FILLING);
    endfunction

endpackage

// File: rtl/dpsram_pingpong_ctrl_if.sv
// Bundles the write stream, read stream and both DPSRAM ports of the controller.
// Latency: n/a (wiring only).
// Backpressure: wr_ready / rd_ready handshakes carried as plain signals.
interface dpsram_pingpong_ctrl_if
    import dpsram_pingpong_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic                  wr_valid;
    logic [DATA_W-1:0]     wr_data;
    logic                  wr_last;
    logic                  wr_ready;

    logic                  rd_valid;
    logic [DATA_W-1:0]     rd_data;
    logic                  rd_last;
    logic                  rd_ready;

    logic [ADDR_W-1:0]     a_addr;
    logic [DATA_W-1:0]     a_din;
    logic                  a_wen;
    logic [DATA_W/8-1:0]   a_wbyte_en;

    logic [ADDR_W-1:0]     b_addr;
    logic                  b_wen;
    logic [DATA_W-1:0]     b_din;
    logic [DATA_W/8-1:0]   b_wbyte_en;
    logic [DATA_W-1:0]     b_dout;

    logic                  bank_ovf;

    modport master (
        input  wr_valid, wr_data, wr_last, rd_ready, b_dout,
        output wr_ready, rd_valid, rd_data, rd_last,
               a_addr, a_din, a_wen, a_wbyte_en,
               b_addr, b_wen, b_din, b_wbyte_en, bank_ovf
    );

    modport slave (
        output wr_valid, wr_data, wr_last, rd_ready, b_dout,
        input  wr_ready, rd_valid, rd_data, rd_last,
               a_addr, a_din, a_wen, a_wbyte_en,
               b_addr, b_wen, b_din, b_wbyte_en, bank_ovf
    );

endinterface

// File: rtl/dpsram_pingpong_ctrl_pp_out_fifo.sv
// Two-entry output FIFO holding {last, data} words read back from the DPSRAM.
// Latency: a pushed word is visible at the head on the following cycle.
// Backpressure: pop side is valid/ready; the producer must keep level + in-flight words within 2.
module pp_out_fifo #(
    parameter int W = 65
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    output logic         pop_vld,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat,
    output logic [1:0]   level
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   cnt;
    logic         push;
    logic         pop;

    assign push    = push_vld && (cnt != 2'd2);
    assign pop     = pop_vld && pop_rdy;
    assign pop_vld = (cnt != 2'd0);
    assign pop_dat = mem[rd_ptr];
    assign level   = cnt;

    // Storage and pointers; reset clears contents so the head reads as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/dpsram_pingpong_ctrl.sv
// Ping-pong bank controller: fills one DPSRAM half via port A while draining the other via port B.
// Latency: first read word valid 2 cycles after a bank closes; 1 word/cycle sustained.
// Backpressure: wr_ready drops while the write bank is busy (word dropped, bank_ovf); reads stall on FIFO credit.
module dpsram_pingpong_ctrl
    import dpsram_pingpong_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                   clk,
    input  logic                   rst,
    dpsram_pingpong_ctrl_if.master bus
);

    localparam int              PTR_W   = ADDR_W - 1;
    localparam logic [PTR_W-1:0] PTR_MAX = '1;

    bank_st_e          bank_st     [2];
    bank_st_e          bank_st_nxt [2];
    logic [ADDR_W-1:0] bank_cnt     [2];
    logic [ADDR_W-1:0] bank_cnt_nxt [2];
    logic [PTR_W-1:0]  wptr, wptr_nxt;
    logic [PTR_W-1:0]  rptr, rptr_nxt;
    logic              wbank, wbank_nxt;
    logic              rbank, rbank_nxt;
    logic              rd_inflight;
    logic              rd_inflight_last;

    logic              wr_rdy;
    logic              wr_hs;
    logic              wr_close;
    logic              rd_select;
    logic              rd_issue;
    logic              rd_issue_last;
    logic              fifo_pop;
    logic [1:0]        fifo_level;
    logic [1:0]        fifo_occ;
    logic [DATA_W:0]   fifo_dat;

    // Bank states, pointers and the one-deep read-in-flight tracker.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_st[0]       <= BANK_EMPTY;
            bank_st[1]       <= BANK_EMPTY;
            bank_cnt[0]      <= '0;
            bank_cnt[1]      <= '0;
            wptr             <= '0;
            rptr             <= '0;
            wbank            <= 1'b0;
            rbank            <= 1'b0;
            rd_inflight      <= 1'b0;
            rd_inflight_last <= 1'b0;
        end else begin
            bank_st          <= bank_st_nxt;
            bank_cnt         <= bank_cnt_nxt;
            wptr             <= wptr_nxt;
            rptr             <= rptr_nxt;
            wbank            <= wbank_nxt;
            rbank            <= rbank_nxt;
            rd_inflight      <= rd_issue;
            rd_inflight_last <= rd_issue && rd_issue_last;
        end
    end

    // Next-state: write side and read side always touch different banks, so both apply.
    always_comb begin
        bank_st_nxt  = bank_st;
        bank_cnt_nxt = bank_cnt;
        wptr_nxt     = wptr;
        wbank_nxt    = wbank;
        rptr_nxt     = rptr;
        rbank_nxt    = rbank;
        if (wr_hs) begin
            if (wr_close) begin
                bank_st_nxt[wbank]  = BANK_FULL;
                bank_cnt_nxt[wbank] = {1'b0, wptr} + ADDR_W'(1);
                wptr_nxt            = '0;
                wbank_nxt           = ~wbank;
            end else begin
                bank_st_nxt[wbank]  = BANK_FILLING;
                wptr_nxt            = wptr + PTR_W'(1);
            end
        end
        if (rd_select) begin
            bank_st_nxt[rbank] = BANK_DRAINING;
        end
        // The bank is released once its last read is issued; the FIFO carries the tail.
        if (rd_issue) begin
            if (rd_issue_last) begin
                bank_st_nxt[rbank] = BANK_EMPTY;
                rptr_nxt           = '0;
                rbank_nxt          = ~rbank;
            end else begin
                rptr_nxt           = rptr + PTR_W'(1);
            end
        end
    end

    // Handshake decisions and port drive; a FULL read bank is selected and issued in one cycle.
    always_comb begin
        wr_rdy        = bank_writable(bank_st[wbank]);
        wr_hs         = bus.wr_valid && wr_rdy;
        wr_close      = wr_hs && (bus.wr_last || (wptr == PTR_MAX));
        rd_select     = (bank_st[rbank] == BANK_FULL);
        fifo_pop      = bus.rd_valid && bus.rd_ready;
        fifo_occ      = fifo_level + {1'b0, rd_inflight} - {1'b0, fifo_pop};
        rd_issue      = (rd_select || (bank_st[rbank] == BANK_DRAINING)) && (fifo_occ < 2'd2);
        rd_issue_last = ({1'b0, rptr} == (bank_cnt[rbank] - ADDR_W'(1)));

        bus.wr_ready   = wr_rdy;
        bus.bank_ovf   = bus.wr_valid && !wr_rdy;
        bus.a_wen      = wr_hs;
        bus.a_wbyte_en = wr_hs ? '1 : '0;
        bus.a_din      = bus.wr_data;
        bus.a_addr     = {wbank, wptr};
        bus.b_addr     = {rbank, rptr};
        bus.b_wen      = 1'b0;
        bus.b_din      = '0;
        bus.b_wbyte_en = '0;
        bus.rd_data    = fifo_dat[DATA_W-1:0];
        bus.rd_last    = fifo_dat[DATA_W];
    end

    pp_out_fifo #(
        .W (DATA_W + 1)
    ) u_out_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (rd_inflight),
        .push_dat ({rd_inflight_last, bus.b_dout}),
        .pop_vld  (bus.rd_valid),
        .pop_rdy  (bus.rd_ready),
        .pop_dat  (fifo_dat),
        .level    (fifo_level)
    );

endmodule

// File: tb/tb_dpsram_pingpong_ctrl.sv
// Bench for dpsram_pingpong_ctrl: DPSRAM model, frame-level scoreboard, directed and random traffic.
module tb_dpsram_pingpong_ctrl;
    import dpsram_pingpong_ctrl_pkg::*;

    localparam int AW = DEF_ADDR_W;
    localparam int DW = DEF_DATA_W;
    localparam int BW = BANK_WORDS;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dpsram_pingpong_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dpsram_pingpong_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int rd_mode = 0;

    // Reference model state: expected output words and the write position within a frame.
    ent_t expq[$];
    int   mbank, mwptr;
    int   acc_cnt, ovf_cnt, pops, lasts;
    int   close_cyc, first_rv_cyc, last_pop_cyc;
    logic seen_rv;
    ent_t mon_e;
    logic mon_last;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // DPSRAM: port A writes with byte enables, port B reads with one cycle of latency.
    always @(posedge clk) begin
        if (bus.a_wen)
            for (int i = 0; i < DW/8; i++)
                if (bus.a_wbyte_en[i]) mem[bus.a_addr][i*8 +: 8] <= bus.a_din[i*8 +: 8];
        bus.b_dout <= mem[bus.b_addr];
    end

    // Monitor: every accepted word joins the expected stream, every popped word is compared.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.wr_valid) begin
                chk("bank_ovf", bus.bank_ovf, !bus.wr_ready);
                chk("a_wen", bus.a_wen, bus.wr_ready);
                if (bus.wr_ready) begin
                    chk("a_addr", bus.a_addr, 64'(mbank * BW + mwptr));
                    chk("a_din", bus.a_din, bus.wr_data);
                    chk("a_wbyte_en", bus.a_wbyte_en, {(DW/8){1'b1}});
                    mon_last = bus.wr_last || (mwptr == BW - 1);
                    mon_e.last = mon_last;
                    mon_e.data = bus.wr_data;
                    expq.push_back(mon_e);
                    acc_cnt++;
                    if (mon_last) begin
                        mwptr = 0;
                        mbank = 1 - mbank;
                        close_cyc = cyc;
                    end else begin
                        mwptr++;
                    end
                end else begin
                    ovf_cnt++;
                end
            end else begin
                chk("a_wen_idle", bus.a_wen, 1'b0);
            end
            if (bus.rd_valid) begin
                if (!seen_rv) first_rv_cyc = cyc;
                seen_rv = 1'b1;
                if (bus.rd_ready) begin
                    chk("rd_extra_word", expq.size() != 0, 1'b1);
                    if (expq.size() != 0) begin
                        mon_e = expq.pop_front();
                        chk("rd_data", bus.rd_data, mon_e.data);
                        chk("rd_last", bus.rd_last, mon_e.last);
                    end
                    if (bus.rd_last) lasts++;
                    pops++;
                    last_pop_cyc = cyc;
                end
            end
        end
    end

    // Read-side ready pattern: 0 low, 1 high, 2 toggle, 3 random.
    initial begin
        bus.rd_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rd_mode)
                0:       bus.rd_ready = 1'b0;
                1:       bus.rd_ready = 1'b1;
                2:       bus.rd_ready = ~bus.rd_ready;
                default: bus.rd_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic idle(input int n);
        bus.wr_valid = 1'b0;
        bus.wr_last  = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Present one word until it is accepted, within a bounded number of cycles.
    task automatic send(input logic [DW-1:0] d, input logic l);
        logic acc;
        int   tries;
        tries = 0;
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        bus.wr_last  = l;
        forever begin
            @(negedge clk);
            acc = bus.wr_ready;
            @(posedge clk); #1;
            if (acc) break;
            tries++;
            if (tries > 3000) begin
                chk("send_timeout", acc, 1'b1);
                break;
            end
        end
        bus.wr_valid = 1'b0;
        bus.wr_last  = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        logic done;
        done = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (expq.size() == 0 && !bus.rd_valid) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain_done", done, 1'b1);
        @(posedge clk); #1;
    endtask

    // One reset cycle, model cleared, then the output reset values are checked.
    task automatic do_reset();
        bus.wr_valid = 1'b0;
        bus.wr_last  = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        expq.delete();
        mbank = 0; mwptr = 0; acc_cnt = 0; ovf_cnt = 0; pops = 0; lasts = 0;
        seen_rv = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_wr_ready", bus.wr_ready, 1'b1);
        chk("rst_rd_valid", bus.rd_valid, 1'b0);
        chk("rst_rd_last", bus.rd_last, 1'b0);
        chk("rst_rd_data", bus.rd_data, 64'h0);
        chk("rst_bank_ovf", bus.bank_ovf, 1'b0);
        chk("rst_a_wen", bus.a_wen, 1'b0);
        chk("rst_a_addr", bus.a_addr, 64'h0);
        chk("rst_b_addr", bus.b_addr, 64'h0);
        chk("b_port_tied", {bus.b_wen, bus.b_wbyte_en, bus.b_din}, 64'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    int len;

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.wr_last  = 1'b0;
        close_cyc = 0; first_rv_cyc = 0; last_pop_cyc = 0;
        do_reset();

        // 512 sequential words fill bank 0 exactly; drain at full rate.
        rd_mode = 1;
        for (int i = 0; i < 512; i++) send(64'(i), 1'b0);
        wait_drain(2000);
        chk("seq_pops", pops, 512);
        chk("seq_lasts", lasts, 1);
        chk("seq_no_ovf", ovf_cnt, 0);
        chk("first_rd_latency", first_rv_cyc - close_cyc, 3);
        chk("drain_rate", last_pop_cyc - first_rv_cyc, 511);

        // Two short frames: 5 words into bank 0, 3 words into bank 1 at address 512.
        do_reset();
        for (int i = 0; i < 5; i++) send({$urandom, $urandom}, i == 4);
        for (int i = 0; i < 3; i++) send({$urandom, $urandom}, i == 2);
        wait_drain(200);
        chk("frames_pops", pops, 8);
        chk("frames_lasts", lasts, 2);

        // Reader stalled: both banks fill, then every further word is dropped.
        do_reset();
        rd_mode = 0;
        for (int i = 0; i < 1100; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 64'(i + 1000);
            bus.wr_last  = 1'b0;
            @(posedge clk); #1;
        end
        bus.wr_valid = 1'b0;
        @(negedge clk);
        chk("ovf_accepted", acc_cnt, 1024);
        chk("ovf_dropped", ovf_cnt, 76);
        chk("ovf_wr_ready", bus.wr_ready, 1'b0);
        @(posedge clk); #1;
        // Drain with a toggling reader.
        rd_mode = 2;
        wait_drain(6000);
        chk("toggle_pops", pops, 1024);
        chk("toggle_lasts", lasts, 2);

        // Random frames, gaps and reader stalls; one frame long enough to auto-close a bank.
        do_reset();
        rd_mode = 3;
        for (int f = 0; f < 6; f++) begin
            len = (f == 2) ? 600 : int'($urandom_range(1, 40));
            for (int w = 0; w < len; w++) begin
                send({$urandom, $urandom}, w == len - 1);
                if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
            end
        end
        wait_drain(20000);
        chk("rand_all_read", pops, acc_cnt);

        // Reset mid-frame, then mid-drain; nothing buffered may reappear.
        do_reset();
        rd_mode = 1;
        for (int i = 0; i < 200; i++) send({$urandom, $urandom}, 1'b0);
        do_reset();
        idle(20);
        chk("no_rd_after_rst_frame", seen_rv, 1'b0);
        for (int i = 0; i < 600; i++) send({$urandom, $urandom}, 1'b0);
        idle(30);
        chk("drain_in_progress", seen_rv, 1'b1);
        do_reset();
        idle(20);
        chk("no_rd_after_rst_drain", seen_rv, 1'b0);
        for (int i = 0; i < 4; i++) send({$urandom, $urandom}, i == 3);
        wait_drain(100);
        chk("post_rst_pops", pops, 4);
        chk("post_rst_lasts", lasts, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dpsram_pingpong_ctrl.md
DPSRAM_PINGPONG_CTRL -- requirements
Module: dpsram_pingpong_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10, meaning total DPSRAM word address width; bank size is 2^(ADDR_W-1) words.
REQ-002 Parameter DATA_W, default 64, meaning DPSRAM word width; byte enables are DATA_W/8 bits wide.
REQ-003 CLK  in  1  single clock for the block and the DPSRAM.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 WR_VALID  in  1  write-side sample word valid.
REQ-006 WR_DATA  in  DATA_W  write-side sample word.
REQ-007 WR_LAST  in  1  marks the final word of a frame, qualified by WR_VALID.
REQ-008 WR_READY  out  1  block accepts a write word this cycle.
REQ-009 RD_VALID  out  1  read-side word valid.
REQ-010 RD_DATA  out  DATA_W  read-side word.
REQ-011 RD_LAST  out  1  marks the final word of a drained bank.
REQ-012 RD_READY  in  1  downstream accepts the read word.
REQ-013 A_ADDR, A_DIN, A_WEN, A_WBYTE_EN  out  ADDR_W, DATA_W, 1, DATA_W/8  DPSRAM port A, write-only.
REQ-014 B_ADDR, B_WEN, B_DIN, B_WBYTE_EN  out  ADDR_W, 1, DATA_W, DATA_W/8  DPSRAM port B, read-only; B_WEN, B_DIN and B_WBYTE_EN are tied to 0.
REQ-015 B_DOUT  in  DATA_W  DPSRAM port B read data, valid 1 cycle after B_ADDR is presented, with output registers bypassed.
REQ-016 BANK_OVF  out  1  one-cycle pulse when a word is dropped because both banks are busy.

Function
REQ-017 Memory split: bank 0 occupies addresses 0..2^(ADDR_W-1)-1; bank 1 occupies the upper half; the bank select is the address MSB.
REQ-018 Each bank has a 2-bit state: EMPTY, FILLING, FULL or DRAINING.
REQ-019 Each bank has a stored word count of ADDR_W bits, range 1..2^(ADDR_W-1).
REQ-020 WR_READY = 1 when the current write bank is EMPTY or FILLING.
REQ-021 A write handshake is WR_VALID and WR_READY; it drives A_WEN = 1, A_WBYTE_EN all ones, A_DIN = WR_DATA and A_ADDR = {bank, wptr} in the same cycle (combinational).
REQ-022 On each write handshake, wptr increments and the bank state becomes FILLING.
REQ-023 The bank closes (state FULL, count = wptr+1, wptr = 0, write bank toggles) on the first of: a handshake with WR_LAST = 1, or a handshake at wptr = 2^(ADDR_W-1)-1.
REQ-024 When WR_VALID = 1 and the write bank is FULL or DRAINING, the word is dropped, BANK_OVF pulses and WR_READY stays 0; no state change results.
REQ-025 Read bank selection: when no bank is DRAINING and a FULL bank exists, the oldest FULL bank (tracked by a read-bank pointer) moves to DRAINING and rptr is set to 0.
REQ-026 Reads are issued by driving B_ADDR = {rbank, rptr}, only while the 2-entry output FIFO has space for all words in flight.
REQ-027 B_DOUT is pushed into the output FIFO one cycle after issue, together with a last flag set when rptr = count-1.
REQ-028 RD_VALID, RD_DATA and RD_LAST come from the FIFO head; the head pops when RD_VALID and RD_READY are both 1.
REQ-029 Throughput: 1 word/cycle sustained when RD_READY is held at 1.
REQ-030 Latency: the first RD_VALID is asserted 2 cycles after the bank becomes FULL.
REQ-031 After the last issued read completes, the bank becomes EMPTY and the read-bank pointer toggles.
REQ-032 The bank returns to EMPTY after the last read is issued, not after it is popped; the FIFO holds the remaining data.
REQ-033 Simultaneous events: a write closing one bank and a drain completing on the other in the same cycle are both applied; the written bank is FULL next cycle.
REQ-034 Writing into a bank and reading from the other bank never conflict; the same address is never accessed by both ports.

Reset
REQ-035 On RST, both banks go EMPTY, wptr, rptr and counts = 0, write and read bank pointers = 0, and the FIFO is flushed.
REQ-036 Output reset values: WR_READY = 1 the cycle after RST, RD_VALID = 0, RD_LAST = 0, RD_DATA = 0, BANK_OVF = 0, A_WEN = 0, A_ADDR = 0, B_ADDR = 0.
REQ-037 RST asserted mid-frame or mid-drain discards all buffered data; no RD_VALID follows until new data is written.

Structure
REQ-038 A shared package holds the bank-state enumeration, the default ADDR_W and DATA_W values, and a BANK_WORDS constant.
REQ-039 One sub-module, pp_out_fifo (2-entry, DATA_W+1 bits, valid/ready), holds the read data and last flag.

Verification
REQ-040 Write 512 words with values 0..511, RD_READY = 1 -> RD_DATA 0..511 in order, RD_LAST on word 511, no BANK_OVF.
REQ-041 Frame of 5 words with WR_LAST on the 5th, then 3 words with WR_LAST -> two read bursts of 5 and 3 words with RD_LAST on each final word; the second burst is read from address 512.
REQ-042 RD_READY = 0 and 1100 words streamed -> 1024 words accepted, BANK_OVF pulses for each of the remaining 76 words, WR_READY = 0 after word 1024.
REQ-043 RD_READY toggling 1/0 every cycle during a drain -> no word lost or duplicated, FIFO never overflows.
REQ-044 RST asserted at word 200 of a frame and again mid-drain -> all outputs return to reset values next cycle; a subsequent 4-word frame reads back correctly from address 0.
